clk_en_gen_multi: RTL and testbench

- Multi-channel, runtime-programmable clock-enable generator. It replaces single fixed-ratio divider-enable instances in the controller.
- Each of NCH channels produces either a one-cycle enable strobe every DIV cycles or a near-50% divided level.
- Each channel has a programmable phase offset and glitch-free reconfiguration through a valid/ready config port.
- A global sync realigns all channels.
- Sits between the controller/verify-platform host registers and downstream engines (AES core pacing, UART/bit-bang timing).

---
 rtl/clk_en_gen_multi.sv | 126 ++++++++++++
 tb/tb_clk_en_gen_multi.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_en_gen_multi.sv
// Multi-channel programmable clock-enable generator: per-channel strobe or divided level
// with phase offset, shadowed reconfiguration committed on period boundaries, and global sync.
module clk_en_gen_multi #(
    parameter int NCH         = 4,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 16,
    localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             run,
    input  logic             sync,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_phase,
    input  logic             cfg_mode,
    output logic [NCH-1:0]   en,
    output logic [NCH-1:0]   pend
);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

    logic           run_q;
    logic           cfg_accept;
    logic [NCH-1:0] wr_sel;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= run;
        end
    end

    // Channel numbers beyond NCH never stall and decode to no channel, so they are dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            if (cfg_ch == CH_W'(k)) begin
                cfg_ready = ~pend[k];
            end
        end
    end

    assign cfg_accept = cfg_valid & cfg_ready;

    always_comb begin
        wr_sel = '0;
        for (int k = 0; k < NCH; k++) begin
            if (cfg_accept && (cfg_ch == CH_W'(k))) begin
                wr_sel[k] = 1'b1;
            end
        end
    end

    genvar i;
    for (i = 0; i < NCH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] div;
        logic [CNT_W-1:0] phase;
        logic             mode;
        logic [CNT_W-1:0] sh_div;
        logic [CNT_W-1:0] sh_phase;
        logic             sh_mode;
        logic             pend_q;

        logic [CNT_W-1:0] n_cur;
        logic [CNT_W-1:0] div_nx;
        logic [CNT_W-1:0] phase_nx;
        logic [CNT_W-1:0] n_new;
        logic [CNT_W-1:0] load_val;
        logic             last;
        logic             commit;
        logic [CNT_W:0]   half;

        // Load value uses the config that will be live next cycle, so a commit and a sync agree.
        always_comb begin
            n_cur    = (div == '0) ? ONE : div;
            last     = (cnt == n_cur - ONE);
            commit   = pend_q & (~run_q | last);
            div_nx   = commit ? sh_div : div;
            phase_nx = commit ? sh_phase : phase;
            n_new    = (div_nx == '0) ? ONE : div_nx;
            load_val = (phase_nx < n_new) ? phase_nx : '0;
            half     = ({1'b0, n_cur} + (CNT_W+1)'(1)) >> 1;
        end

        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                cnt      <= '0;
                div      <= DEF_DIV;
                phase    <= '0;
                mode     <= 1'b0;
                sh_div   <= '0;
                sh_phase <= '0;
                sh_mode  <= 1'b0;
                pend_q   <= 1'b0;
            end else begin
                if (sync || commit) begin
                    cnt <= load_val;
                end else if (run_q) begin
                    cnt <= last ? '0 : cnt + ONE;
                end

                if (commit) begin
                    div    <= sh_div;
                    phase  <= sh_phase;
                    mode   <= sh_mode;
                    pend_q <= 1'b0;
                end else if (wr_sel[i]) begin
                    sh_div   <= cfg_div;
                    sh_phase <= cfg_phase;
                    sh_mode  <= cfg_mode;
                    pend_q   <= 1'b1;
                end
            end
        end

        assign en[i]   = run_q & (mode ? ({1'b0, cnt} < half) : (cnt == '0));
        assign pend[i] = pend_q;
    end

endmodule

// File: tb/tb_clk_en_gen_multi.sv
// Self-checking bench for clk_en_gen_multi: directed scenarios plus random traffic,
// all compared cycle by cycle against an integer reference model of the channel rules.
module tb_clk_en_gen_multi;

    localparam int NCH   = 4;
    localparam int CNT_W = 16;

    logic             clk_in = 1'b0;
    logic             rst_n;
    logic             run, sync, cfg_valid, cfg_mode;
    logic [1:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_div, cfg_phase;
    logic             cfg_ready;
    logic [NCH-1:0]   en, pend;

    logic             cfg_valid3;
    logic [1:0]       cfg_ch3;
    logic             cfg_ready3;
    logic [2:0]       en3, pend3;

    int checks   = 0;
    int failures = 0;

    int m_cnt[NCH], m_div[NCH], m_phase[NCH], m_mode[NCH];
    int m_sh_div[NCH], m_sh_phase[NCH], m_sh_mode[NCH], m_pend[NCH];
    bit m_runq;

    always #5 clk_in = ~clk_in;

    clk_en_gen_multi #(.NCH(NCH), .CNT_W(CNT_W), .DEFAULT_DIV(16)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .run(run), .sync(sync),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_mode(cfg_mode),
        .en(en), .pend(pend)
    );

    // Three-channel instance so that an out-of-range channel number is reachable.
    clk_en_gen_multi #(.NCH(3), .CNT_W(8), .DEFAULT_DIV(4)) dut3 (
        .clk_in(clk_in), .rst_n(rst_n), .run(1'b0), .sync(1'b0),
        .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3), .cfg_ch(cfg_ch3),
        .cfg_div(8'd5), .cfg_phase(8'd0), .cfg_mode(1'b0),
        .en(en3), .pend(pend3)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int effN(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic logic [NCH-1:0] expEn();
        logic [NCH-1:0] v = '0;
        for (int i = 0; i < NCH; i++) begin
            int n = effN(m_div[i]);
            if (m_runq)
                v[i] = (m_mode[i] != 0) ? (m_cnt[i] < (n + 1) / 2) : (m_cnt[i] == 0);
        end
        return v;
    endfunction

    function automatic logic [NCH-1:0] expPend();
        logic [NCH-1:0] v = '0;
        for (int i = 0; i < NCH; i++) v[i] = (m_pend[i] != 0);
        return v;
    endfunction

    task automatic modelReset();
        m_runq = 0;
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i] = 0; m_div[i] = 16; m_phase[i] = 0; m_mode[i] = 0;
            m_sh_div[i] = 0; m_sh_phase[i] = 0; m_sh_mode[i] = 0; m_pend[i] = 0;
        end
    endtask

    task automatic modelStep(input bit r, input bit s, input bit v, input int ch,
                             input int d, input int p, input int m, output bit acc);
        acc = v && (m_pend[ch] == 0);
        for (int i = 0; i < NCH; i++) begin
            int  n_old = effN(m_div[i]);
            bit  commit = (m_pend[i] != 0) && (!m_runq || m_cnt[i] == n_old - 1);
            int  n, start;
            if (commit) begin
                m_div[i] = m_sh_div[i]; m_phase[i] = m_sh_phase[i];
                m_mode[i] = m_sh_mode[i]; m_pend[i] = 0;
            end
            n     = effN(m_div[i]);
            start = (m_phase[i] < n) ? m_phase[i] : 0;
            if (s || commit)  m_cnt[i] = start;
            else if (m_runq)  m_cnt[i] = (m_cnt[i] + 1) % n_old;
            if (acc && ch == i) begin
                m_sh_div[i] = d; m_sh_phase[i] = p; m_sh_mode[i] = m; m_pend[i] = 1;
            end
        end
        m_runq = r;
    endtask

    // Called at a falling edge; drives one cycle of inputs and checks the following state.
    task automatic applyStimulus(input bit r, input bit s, input bit v, input int ch,
                                 input int d, input int p, input int m, output bit acc);
        run = r; sync = s; cfg_valid = v; cfg_ch = 2'(ch);
        cfg_div = CNT_W'(d); cfg_phase = CNT_W'(p); cfg_mode = m[0];
        #1;
        checkOutput("cfg_ready", {31'd0, cfg_ready}, {31'd0, (m_pend[ch] == 0)});
        modelStep(r, s, v, ch, d, p, m, acc);
        @(negedge clk_in);
        checkOutput("en", {28'd0, en}, {28'd0, expEn()});
        checkOutput("pend", {28'd0, pend}, {28'd0, expPend()});
    endtask

    task automatic idle(input int cycles, input bit r);
        bit acc;
        for (int k = 0; k < cycles; k++) applyStimulus(r, 0, 0, 0, 0, 0, 0, acc);
    endtask

    task automatic writeCh(input bit r, input int ch, input int d, input int p, input int m,
                           output int stalls);
        bit acc = 0;
        stalls = 0;
        for (int k = 0; k < 300 && !acc; k++) begin
            applyStimulus(r, 0, 1, ch, d, p, m, acc);
            if (!acc) stalls++;
        end
        if (!acc) checkOutput("write_timeout", 32'd0, 32'd1);
    endtask

    task automatic doSync(input bit r);
        bit acc;
        applyStimulus(r, 1, 0, 0, 0, 0, 0, acc);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int stalls;
        bit acc;

        rst_n = 1'b0; run = 0; sync = 0; cfg_valid = 0; cfg_ch = 0;
        cfg_div = 0; cfg_phase = 0; cfg_mode = 0; cfg_valid3 = 0; cfg_ch3 = 0;
        modelReset();
        #12;
        checkOutput("rst_en", {28'd0, en}, 32'd0);
        checkOutput("rst_pend", {28'd0, pend}, 32'd0);
        checkOutput("rst_ready", {31'd0, cfg_ready}, 32'd1);
        @(negedge clk_in);
        rst_n = 1'b1;

        cfg_valid3 = 1'b1; cfg_ch3 = 2'd3;
        #1 checkOutput("oor_ready", {31'd0, cfg_ready3}, 32'd1);
        idle(1, 0);
        checkOutput("oor_pend", {29'd0, pend3}, 32'd0);
        cfg_ch3 = 2'd0;
        idle(1, 0);
        checkOutput("ch0_pend3", {29'd0, pend3}, 32'd1);
        cfg_valid3 = 1'b0;
        idle(1, 0);
        checkOutput("ch0_commit3", {29'd0, pend3}, 32'd0);

        idle(40, 1);
        writeCh(1, 1, 5, 0, 0, stalls);
        writeCh(1, 1, 5, 0, 0, stalls);
        checkOutput("stall_seen", {31'd0, (stalls > 0)}, 32'd1);
        idle(20, 1);

        writeCh(1, 2, 3, 0, 1, stalls);
        writeCh(1, 3, 1, 0, 0, stalls);
        idle(20, 1);

        writeCh(1, 0, 8, 6, 0, stalls);
        writeCh(1, 1, 8, 0, 0, stalls);
        idle(20, 1);
        doSync(1);
        idle(20, 1);
        writeCh(1, 2, 8, 9, 0, stalls);
        idle(20, 1);
        doSync(1);
        idle(10, 1);

        writeCh(1, 0, 0, 0, 0, stalls);
        idle(10, 1);
        idle(5, 0);
        idle(10, 1);

        writeCh(1, 3, 16'hFFFF, 16'hFFFE, 1, stalls);
        idle(4, 1);
        doSync(1);
        idle(6, 1);
        writeCh(0, 3, 4, 1, 0, stalls);
        idle(3, 0);
        doSync(1);
        idle(10, 1);

        for (int k = 0; k < 3000; k++) begin
            bit r  = ($urandom % 10) != 0;
            bit s  = ($urandom % 30) == 0;
            bit v  = ($urandom % 4) == 0;
            int ch = $urandom % NCH;
            int d  = (($urandom % 8) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 10);
            int p  = $urandom_range(0, 12);
            int m  = $urandom % 2;
            applyStimulus(r, s, v, ch, d, p, m, acc);
        end

        idle(2, 1);
        writeCh(1, 2, 9, 0, 0, stalls);
        checkOutput("pend2_before_rst", {31'd0, pend[2]}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_en", {28'd0, en}, 32'd0);
        checkOutput("midrst_pend", {28'd0, pend}, 32'd0);
        modelReset();
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b1;
        idle(40, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
